// File: rtl/gpu_blitter.sv
// Sprite blitter / clear engine: clips sprites to the framebuffer and fetches pixels over a req/ready/rvalid port.
// Optional horizontal mirroring is built when GPU_BLITTER_FLIP_EN is defined.
module gpu_blitter #(
    parameter int FB_WIDTH  = 160,
    parameter int FB_HEIGHT = 120,
    parameter int FB_XW     = 8,
    parameter int FB_YW     = 8,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] ctrl_address,
    input  logic [15:0]       ctrl_address_x,
    input  logic [15:0]       ctrl_address_y,
    input  logic [15:0]       ctrl_sheetsize,
    input  logic [15:0]       ctrl_width,
    input  logic [15:0]       ctrl_height,
    input  logic [15:0]       ctrl_x,
    input  logic [15:0]       ctrl_y,
    input  logic              ctrl_draw,
    input  logic [15:0]       ctrl_clear_color,
    input  logic              ctrl_clear,
    input  logic              ctrl_flip_x,
    output logic              ctrl_busy,
    output logic              ctrl_done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [15:0]       mem_rdata,
    output logic [FB_XW-1:0]  fb_x,
    output logic [FB_YW-1:0]  fb_y,
    output logic [15:0]       fb_color,
    output logic              fb_write
);
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SCAN, S_REQ, S_WAIT, S_WRITE} state_t;

    localparam logic signed [16:0] FB_W_S = 17'(FB_WIDTH);
    localparam logic signed [16:0] FB_H_S = 17'(FB_HEIGHT);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [15:0]       ax_q, ax_d, ay_q, ay_d, pitch_q, pitch_d;
    logic [15:0]       width_q, width_d, height_q, height_d;
    logic [15:0]       x_q, x_d, y_q, y_d, clr_q, clr_d;
    logic [15:0]       col_q, col_d, row_q, row_d, rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              flip_q, flip_d;

    logic signed [16:0] dx, dy;
    logic               clipped, last_col, last_row;
    logic [15:0]        src_col;
    logic [ADDR_W-1:0]  src_addr;

    assign dx       = $signed({x_q[15], x_q}) + $signed({1'b0, col_q});
    assign dy       = $signed({y_q[15], y_q}) + $signed({1'b0, row_q});
    assign clipped  = (dx < 0) || (dx >= FB_W_S) || (dy < 0) || (dy >= FB_H_S);
    assign last_col = (col_q == width_q - 16'd1);
    assign last_row = (row_q == height_q - 16'd1);

`ifdef GPU_BLITTER_FLIP_EN
    assign flip_d  = (state_q == S_IDLE && ctrl_draw) ? ctrl_flip_x : flip_q;
    assign src_col = flip_q ? (width_q - 16'd1 - col_q) : col_q;
`else
    logic unused_flip;
    assign unused_flip = ctrl_flip_x;
    assign flip_d      = 1'b0;
    assign src_col     = col_q;
`endif

    // All terms are reduced modulo 2^ADDR_W, so truncating each operand first is exact.
    assign src_addr = base_q + (ADDR_W'(ay_q) + ADDR_W'(row_q)) * ADDR_W'(pitch_q)
                    + ADDR_W'(ax_q) + ADDR_W'(src_col);

    assign ctrl_busy = (state_q != S_IDLE);
    assign ctrl_done = done_q;
    assign mem_req   = (state_q == S_REQ);
    assign mem_addr  = (state_q == S_REQ) ? src_addr : '0;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        ax_d     = ax_q;
        ay_d     = ay_q;
        pitch_d  = pitch_q;
        width_d  = width_q;
        height_d = height_q;
        x_d      = x_q;
        y_d      = y_q;
        clr_d    = clr_q;
        col_d    = col_q;
        row_d    = row_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        fb_write = 1'b0;
        fb_x     = '0;
        fb_y     = '0;
        fb_color = '0;
        case (state_q)
            S_IDLE: begin
                col_d = '0;
                row_d = '0;
                if (ctrl_draw) begin
                    base_d   = ctrl_address;
                    ax_d     = ctrl_address_x;
                    ay_d     = ctrl_address_y;
                    pitch_d  = ctrl_sheetsize;
                    width_d  = ctrl_width;
                    height_d = ctrl_height;
                    x_d      = ctrl_x;
                    y_d      = ctrl_y;
                    state_d  = S_SCAN;
                end else if (ctrl_clear) begin
                    clr_d   = ctrl_clear_color;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                fb_write = 1'b1;
                fb_x     = col_q[FB_XW-1:0];
                fb_y     = row_q[FB_YW-1:0];
                fb_color = clr_q;
                if (col_q == 16'(FB_WIDTH - 1)) begin
                    col_d = '0;
                    if (row_q == 16'(FB_HEIGHT - 1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + 16'd1;
                    end
                end else begin
                    col_d = col_q + 16'd1;
                end
            end
            S_SCAN: begin
                if (width_q == '0 || height_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (!clipped) begin
                    state_d = S_REQ;
                end else if (last_col && last_row) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (last_col) begin
                    col_d = '0;
                    row_d = row_q + 16'd1;
                end else begin
                    col_d = col_q + 16'd1;
                end
            end
            S_REQ: begin
                if (mem_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                fb_write = rdata_q[0];
                fb_x     = dx[FB_XW-1:0];
                fb_y     = dy[FB_YW-1:0];
                fb_color = rdata_q;
                if (last_col && last_row) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (last_col) begin
                    col_d   = '0;
                    row_d   = row_q + 16'd1;
                    state_d = S_SCAN;
                end else begin
                    col_d   = col_q + 16'd1;
                    state_d = S_SCAN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            ax_q     <= '0;
            ay_q     <= '0;
            pitch_q  <= '0;
            width_q  <= '0;
            height_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            clr_q    <= '0;
            col_q    <= '0;
            row_q    <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            flip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            ax_q     <= ax_d;
            ay_q     <= ay_d;
            pitch_q  <= pitch_d;
            width_q  <= width_d;
            height_q <= height_d;
            x_q      <= x_d;
            y_q      <= y_d;
            clr_q    <= clr_d;
            col_q    <= col_d;
            row_q    <= row_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            flip_q   <= flip_d;
        end
    end
endmodule

// File: tb/tb_gpu_blitter.sv
// Directed bench for gpu_blitter with a fixed-latency memory responder and a framebuffer write logger.
module tb_gpu_blitter;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] ctrl_address;
    logic [15:0] ctrl_address_x, ctrl_address_y, ctrl_sheetsize, ctrl_width, ctrl_height;
    logic [15:0] ctrl_x, ctrl_y, ctrl_clear_color;
    logic        ctrl_draw, ctrl_clear, ctrl_flip_x;
    logic        ctrl_busy, ctrl_done, mem_req, mem_ready, mem_rvalid, fb_write;
    logic [31:0] mem_addr;
    logic [15:0] mem_rdata, fb_color;
    logic [7:0]  fb_x, fb_y;

    always #5 clk = ~clk;

    gpu_blitter #(.FB_WIDTH(160), .FB_HEIGHT(120), .FB_XW(8), .FB_YW(8), .ADDR_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .ctrl_address(ctrl_address), .ctrl_address_x(ctrl_address_x), .ctrl_address_y(ctrl_address_y),
        .ctrl_sheetsize(ctrl_sheetsize), .ctrl_width(ctrl_width), .ctrl_height(ctrl_height),
        .ctrl_x(ctrl_x), .ctrl_y(ctrl_y), .ctrl_draw(ctrl_draw),
        .ctrl_clear_color(ctrl_clear_color), .ctrl_clear(ctrl_clear), .ctrl_flip_x(ctrl_flip_x),
        .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_write(fb_write)
    );

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] fetch_q[$];
    int          wr_x[$];
    int          wr_y[$];
    logic [15:0] wr_c[$];
    int          lat_cnt = 0, stall_left = 0, stall_seen = 0, stall_bad = 0, data_mode = 0;
    logic [31:0] resp_addr, stall_addr;

    function automatic logic [15:0] mem_model(input logic [31:0] a);
        if (data_mode == 0) return {a[14:0], 1'b1};
        return a[0] ? 16'h0001 : 16'hFFFE;
    endfunction

    // Memory: optional initial stall, then ready for one cycle and rvalid LAT cycles later.
    initial begin
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0; mem_rvalid = 1'b0;
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_model(resp_addr);
                end
            end else if (mem_req === 1'b1) begin
                if (stall_left > 0) begin
                    if (stall_seen == 0) stall_addr = mem_addr;
                    else if (mem_addr !== stall_addr) stall_bad++;
                    stall_seen++;
                    stall_left--;
                end else begin
                    if (stall_seen > 0 && fetch_q.size() == 0 && mem_addr !== stall_addr) stall_bad++;
                    mem_ready = 1'b1;
                    resp_addr = mem_addr;
                    lat_cnt   = LAT;
                    fetch_q.push_back(mem_addr);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (fb_write === 1'b1) begin
                wr_x.push_back(int'(fb_x));
                wr_y.push_back(int'(fb_y));
                wr_c.push_back(fb_color);
            end
        end
    end

    task automatic clear_logs();
        fetch_q.delete(); wr_x.delete(); wr_y.delete(); wr_c.delete();
    endtask

    task automatic set_cmd(input logic [31:0] base, input logic [15:0] ax, input logic [15:0] ay,
                           input logic [15:0] pitch, input logic [15:0] w, input logic [15:0] h,
                           input logic [15:0] x, input logic [15:0] y, input logic flip);
        ctrl_address = base; ctrl_address_x = ax; ctrl_address_y = ay; ctrl_sheetsize = pitch;
        ctrl_width = w; ctrl_height = h; ctrl_x = x; ctrl_y = y; ctrl_flip_x = flip;
    endtask

    task automatic pulse(input logic d, input logic c);
        @(negedge clk);
        ctrl_draw = d; ctrl_clear = c;
        @(negedge clk);
        ctrl_draw = 1'b0; ctrl_clear = 1'b0;
        tests_run++;
        if (ctrl_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_rise: busy=%b required 1", ctrl_busy);
        end
    endtask

    task automatic wait_done(input int budget, output int cycles);
        bit seen;
        seen = 0;
        cycles = 1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ctrl_done === 1'b1) begin seen = 1; break; end
            if (ctrl_busy === 1'b1) cycles++;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL done_timeout: no done within %0d cycles, required done pulse", budget);
        end else begin
            tests_run++;
            if (ctrl_busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL busy_at_done: busy=%b required 0", ctrl_busy);
            end
            @(negedge clk);
            tests_run++;
            if (ctrl_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL done_width: done=%b one cycle later, required 0", ctrl_done);
            end
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic check_write(input int idx, input int ex, input int ey, input logic [15:0] ec);
        tests_run++;
        if (idx >= wr_x.size()) begin
            tests_failed++;
            $display("FAIL write%0d: missing, required (%0d,%0d) %h", idx, ex, ey, ec);
        end else if (wr_x[idx] !== ex || wr_y[idx] !== ey || wr_c[idx] !== ec) begin
            tests_failed++;
            $display("FAIL write%0d: got (%0d,%0d) %h required (%0d,%0d) %h",
                     idx, wr_x[idx], wr_y[idx], wr_c[idx], ex, ey, ec);
        end
    endtask

    task automatic check_fetch(input int idx, input logic [31:0] ea);
        tests_run++;
        if (idx >= fetch_q.size()) begin
            tests_failed++;
            $display("FAIL fetch%0d: missing, required %h", idx, ea);
        end else if (fetch_q[idx] !== ea) begin
            tests_failed++;
            $display("FAIL fetch%0d: got %h required %h", idx, fetch_q[idx], ea);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        ctrl_draw = 1'b0; ctrl_clear = 1'b0; ctrl_clear_color = '0;
        set_cmd(32'h0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
        repeat (3) @(negedge clk);
        tests_run++;
        if ({ctrl_busy, ctrl_done, mem_req, fb_write} !== 4'b0 || mem_addr !== '0 ||
            fb_x !== '0 || fb_y !== '0 || fb_color !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: busy=%b done=%b req=%b wr=%b addr=%h x=%0d y=%0d c=%h required all 0",
                     ctrl_busy, ctrl_done, mem_req, fb_write, mem_addr, fb_x, fb_y, fb_color);
        end
        rstn = 1'b1;
        @(negedge clk);
        $display("[TB] reset checked");
    endtask

    task automatic test_clear();
        logic [15:0] colors [2];
        int cyc, bad;
        colors[0] = 16'h1235;
        colors[1] = 16'h1234;
        for (int k = 0; k < 2; k++) begin
            clear_logs();
            ctrl_clear_color = colors[k];
            pulse(1'b0, 1'b1);
            wait_done(20000, cyc);
            check_int("clear_busy_cycles", cyc, 19200);
            check_int("clear_write_count", wr_x.size(), 19200);
            bad = 0;
            for (int i = 0; i < wr_x.size(); i++)
                if (wr_x[i] !== i % 160 || wr_y[i] !== i / 160 || wr_c[i] !== colors[k]) bad++;
            check_int("clear_pixel_errors", bad, 0);
            check_int("clear_fetches", fetch_q.size(), 0);
            $display("[TB] clear %h: %0d busy cycles, %0d writes", colors[k], cyc, wr_x.size());
        end
    endtask

    task automatic test_draw();
        int cyc;
        logic [31:0] a;
        clear_logs();
        data_mode = 0;
        set_cmd(32'h1000, 16'd2, 16'd3, 16'd64, 16'd4, 16'd2, 16'd10, 16'd20, 1'b0);
        pulse(1'b1, 1'b0);
        wait_done(500, cyc);
        check_int("draw_busy_cycles", cyc, 48);
        check_int("draw_fetch_count", fetch_q.size(), 8);
        check_int("draw_write_count", wr_x.size(), 8);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) begin
                a = (r == 0) ? 32'h10C2 + 32'(c) : 32'h1102 + 32'(c);
                check_fetch(r * 4 + c, a);
                check_write(r * 4 + c, 10 + c, 20 + r, {a[14:0], 1'b1});
            end
        $display("[TB] draw 4x2 at (10,20): %0d fetches, %0d writes", fetch_q.size(), wr_x.size());
    endtask

    task automatic test_clip();
        int cyc;
        clear_logs();
        set_cmd(32'h1000, 16'd2, 16'd3, 16'd64, 16'd4, 16'd2, 16'hFFFE, 16'd119, 1'b0);
        pulse(1'b1, 1'b0);
        wait_done(500, cyc);
        check_int("clip_busy_cycles", cyc, 18);
        check_int("clip_fetch_count", fetch_q.size(), 2);
        check_int("clip_write_count", wr_x.size(), 2);
        check_fetch(0, 32'h10C4);
        check_fetch(1, 32'h10C5);
        check_write(0, 0, 119, {15'h10C4, 1'b1});
        check_write(1, 1, 119, {15'h10C5, 1'b1});
        $display("[TB] clipped draw at (-2,119): %0d fetches, %0d writes", fetch_q.size(), wr_x.size());
        clear_logs();
        set_cmd(32'h1000, 16'd2, 16'd3, 16'd64, 16'd4, 16'd2, 16'd200, 16'd5, 1'b0);
        pulse(1'b1, 1'b0);
        wait_done(500, cyc);
        check_int("offscreen_busy_cycles", cyc, 8);
        check_int("offscreen_fetch_count", fetch_q.size(), 0);
        check_int("offscreen_write_count", wr_x.size(), 0);
        $display("[TB] off-screen draw at (200,5): %0d busy cycles", cyc);
    endtask

    task automatic test_opaque_stall();
        int cyc;
        clear_logs();
        data_mode  = 1;
        stall_seen = 0;
        stall_bad  = 0;
        stall_left = 5;
        set_cmd(32'h0, 16'd0, 16'd0, 16'd64, 16'd4, 16'd1, 16'd0, 16'd0, 1'b0);
        pulse(1'b1, 1'b0);
        wait_done(500, cyc);
        check_int("stall_busy_cycles", cyc, 29);
        check_int("stall_cycles_seen", stall_seen, 5);
        check_int("stall_addr_changes", stall_bad, 0);
        check_int("stall_fetch_count", fetch_q.size(), 4);
        for (int i = 0; i < 4; i++) check_fetch(i, 32'(i));
        check_int("opaque_write_count", wr_x.size(), 2);
        check_write(0, 1, 0, 16'h0001);
        check_write(1, 3, 0, 16'h0001);
        data_mode  = 0;
        stall_seen = 0;
        $display("[TB] transparency + 5-cycle stall: %0d fetches, %0d writes", fetch_q.size(), wr_x.size());
    endtask

    task automatic test_cmd_priority();
        int cyc;
        clear_logs();
        ctrl_clear_color = 16'hABCD;
        set_cmd(32'h20, 16'd0, 16'd0, 16'd16, 16'd1, 16'd1, 16'd5, 16'd5, 1'b0);
        pulse(1'b1, 1'b1);
        set_cmd(32'h40, 16'd0, 16'd0, 16'd16, 16'd1, 16'd1, 16'd7, 16'd7, 1'b0);
        pulse(1'b1, 1'b1);
        wait_done(500, cyc);
        repeat (30) @(negedge clk);
        check_int("prio_idle_after", int'(ctrl_busy), 0);
        check_int("prio_fetch_count", fetch_q.size(), 1);
        check_fetch(0, 32'h20);
        check_int("prio_write_count", wr_x.size(), 1);
        check_write(0, 5, 5, {15'h20, 1'b1});
        $display("[TB] draw+clear together, draw while busy: %0d writes", wr_x.size());
        clear_logs();
        set_cmd(32'h20, 16'd0, 16'd0, 16'd16, 16'd0, 16'd3, 16'd5, 16'd5, 1'b0);
        pulse(1'b1, 1'b0);
        wait_done(50, cyc);
        check_int("zero_size_busy_cycles", cyc, 1);
        check_int("zero_size_fetches", fetch_q.size(), 0);
        $display("[TB] zero-width draw: %0d busy cycles", cyc);
    endtask

    task automatic test_reset_abort();
        bit got;
        clear_logs();
        got = 0;
        set_cmd(32'h80, 16'd0, 16'd0, 16'd16, 16'd1, 16'd1, 16'd3, 16'd3, 1'b0);
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (fetch_q.size() > 0) begin got = 1; break; end
        end
        check_int("abort_fetch_seen", int'(got), 1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        tests_run++;
        if ({ctrl_busy, ctrl_done, mem_req, fb_write} !== 4'b0) begin
            tests_failed++;
            $display("FAIL abort_outputs: busy=%b done=%b req=%b wr=%b required all 0",
                     ctrl_busy, ctrl_done, mem_req, fb_write);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (8) @(negedge clk);
        check_int("abort_late_rvalid_writes", wr_x.size(), 0);
        check_int("abort_idle", int'(ctrl_busy), 0);
        $display("[TB] reset during WAIT: %0d writes after late rvalid", wr_x.size());
    endtask

`ifdef GPU_BLITTER_FLIP_EN
    task automatic test_flip();
        int cyc;
        clear_logs();
        set_cmd(32'h1000, 16'd2, 16'd3, 16'd64, 16'd4, 16'd1, 16'd10, 16'd20, 1'b1);
        pulse(1'b1, 1'b0);
        wait_done(500, cyc);
        check_fetch(0, 32'h10C5);
        check_fetch(3, 32'h10C2);
        check_write(0, 10, 20, {15'h10C5, 1'b1});
        ctrl_flip_x = 1'b0;
        $display("[TB] flipped draw: first fetch %h", fetch_q.size() > 0 ? fetch_q[0] : 32'h0);
    endtask
`endif

    initial begin
        test_reset();
        test_clear();
        test_draw();
        test_clip();
        test_opaque_stall();
        test_cmd_priority();
        test_reset_abort();
`ifdef GPU_BLITTER_FLIP_EN
        test_flip();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
